// File: rtl/tinker_reg_dump.sv
// tinker_reg_dump: after halt, streams registers FIRST_REG..FIRST_REG+NUM_REGS-1 little-endian as bytes
module tinker_reg_dump #(
  parameter int NUM_REGS  = 32,
  parameter int FIRST_REG = 0,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hlt,
  output logic [4:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte,
  output logic [4:0]        tx_reg,
  output logic [2:0]        tx_byte_idx,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  // full-width sum narrowed once; FIRST_REG+NUM_REGS <= 32 keeps it in 0..31
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(FIRST_REG + NUM_REGS - 1);
  state_t            state_q;
  logic [4:0]        idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              valid_q, last_q, busy_q, done_q;
  logic [4:0]        reg_q;
  logic [2:0]        bidx_q;
  assign rf_rd_addr  = idx_q;
  assign tx_byte     = shift_q[7:0];
  assign tx_valid    = valid_q;
  assign tx_reg      = reg_q;
  assign tx_byte_idx = bidx_q;
  assign tx_last     = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= FIRST;
      shift_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      reg_q   <= '0;
      bidx_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (hlt) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
        end
        LOAD: begin
          shift_q <= rf_rd_data;
          bidx_q  <= '0;
          reg_q   <= idx_q;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          state_q <= SEND;
        end
        SEND: if (tx_ready) begin
          if (bidx_q != 3'd7) begin
            shift_q <= shift_q >> 8;
            bidx_q  <= bidx_q + 3'd1;
            last_q  <= (idx_q == LAST) && (bidx_q == 3'd6);
          end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (idx_q == LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= LOAD;
            end
          end
        end
        DONE: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tinker_reg_dump.sv
// tb_tinker_reg_dump: directed checks of the register dump stream, full range and a subrange instance
module tb_tinker_reg_dump;
  typedef struct packed {logic [7:0] b; logic [4:0] r; logic [2:0] i; logic l;} rec_t;
  typedef struct {int pos; rec_t e;} vec_t;
  logic clk = 0, reset = 1, hlt = 0, tx_ready = 1, hlt2 = 0, tx_ready2 = 1;
  logic [4:0] rf_rd_addr, rf_rd_addr2, tx_reg, tx_reg2;
  logic [63:0] rf_rd_data, rf_rd_data2;
  logic [63:0] rfa [32];
  logic [63:0] rfb [32];
  logic tx_valid, tx_last, busy, done, tx_valid2, tx_last2, busy2, done2;
  logic [7:0] tx_byte, tx_byte2;
  logic [2:0] tx_byte_idx, tx_byte_idx2;
  rec_t qa[$];
  rec_t qb[$];
  vec_t tv[12];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign rf_rd_data  = rfa[rf_rd_addr];
  assign rf_rd_data2 = rfb[rf_rd_addr2];
  tinker_reg_dump dut_a (
    .clk(clk), .reset(reset), .hlt(hlt), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_reg(tx_reg),
    .tx_byte_idx(tx_byte_idx), .tx_last(tx_last), .busy(busy), .done(done));
  tinker_reg_dump #(.NUM_REGS(2), .FIRST_REG(29)) dut_b (
    .clk(clk), .reset(reset), .hlt(hlt2), .rf_rd_addr(rf_rd_addr2), .rf_rd_data(rf_rd_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_byte(tx_byte2), .tx_reg(tx_reg2),
    .tx_byte_idx(tx_byte_idx2), .tx_last(tx_last2), .busy(busy2), .done(done2));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // capture every transferring byte; a held byte must not change while stalled
  logic held = 0;
  rec_t held_v;
  always @(negedge clk) begin
    if (!reset && tx_valid) begin
      if (held) chk("stable_while_stalled", {tx_byte, tx_reg, tx_byte_idx, tx_last}, held_v);
      if (tx_ready) begin
        qa.push_back({tx_byte, tx_reg, tx_byte_idx, tx_last});
        held = 0;
      end else begin
        held = 1;
        held_v = {tx_byte, tx_reg, tx_byte_idx, tx_last};
      end
    end else held = 0;
    if (!reset && tx_valid2 && tx_ready2) qb.push_back({tx_byte2, tx_reg2, tx_byte_idx2, tx_last2});
  end
  task automatic wait_done(input bit bs, input bit rnd, input int start, input int limit, output int cyc);
    cyc = start;
    while (!(bs ? done2 : done) && cyc < limit) begin
      if (rnd) tx_ready = ($urandom_range(0, 9) < 3);
      tick;
      cyc++;
    end
    tx_ready = 1;
    chk(bs ? "b_done_reached" : "a_done_reached", bs ? done2 : done, 1);
  endtask
  task automatic check_stream(input bit bs);
    int n, first, sz, r, i;
    logic [63:0] w;
    rec_t got, exp;
    n = bs ? 2 : 32;
    first = bs ? 29 : 0;
    sz = bs ? qb.size() : qa.size();
    chk(bs ? "b_byte_count" : "a_byte_count", sz, n * 8);
    for (int p = 0; p < sz && p < n * 8; p++) begin
      r = first + p / 8;
      i = p % 8;
      w = bs ? rfb[r] : rfa[r];
      exp = {w[8*i +: 8], 5'(r), 3'(i), p == n * 8 - 1};
      got = bs ? qb[p] : qa[p];
      chk(bs ? "b_stream" : "a_stream", got, exp);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc, n0;
    for (int k = 0; k < 32; k++) begin
      rfa[k] = '0;
      rfb[k] = '0;
    end
    rfa[16] = 64'd247;
    rfa[17] = 64'd162;
    rfa[24] = $realtobits(10.0);
    rfb[29] = 64'd36;
    rfb[30] = 64'd12;
    tv[0]  = '{0,   '{8'h00, 5'd0,  3'd0, 1'b0}};
    tv[1]  = '{128, '{8'hF7, 5'd16, 3'd0, 1'b0}};
    tv[2]  = '{129, '{8'h00, 5'd16, 3'd1, 1'b0}};
    tv[3]  = '{135, '{8'h00, 5'd16, 3'd7, 1'b0}};
    tv[4]  = '{136, '{8'hA2, 5'd17, 3'd0, 1'b0}};
    tv[5]  = '{137, '{8'h00, 5'd17, 3'd1, 1'b0}};
    tv[6]  = '{192, '{8'h00, 5'd24, 3'd0, 1'b0}};
    tv[7]  = '{197, '{8'h00, 5'd24, 3'd5, 1'b0}};
    tv[8]  = '{198, '{8'h24, 5'd24, 3'd6, 1'b0}};
    tv[9]  = '{199, '{8'h40, 5'd24, 3'd7, 1'b0}};
    tv[10] = '{254, '{8'h00, 5'd31, 3'd6, 1'b0}};
    tv[11] = '{255, '{8'h00, 5'd31, 3'd7, 1'b1}};
    repeat (2) tick;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {tx_byte, tx_reg, tx_byte_idx, tx_last}, 0);
    chk("rst_addr_a", rf_rd_addr, 0);
    chk("rst_addr_b", rf_rd_addr2, 29);
    reset = 0;
    tick;
    chk("idle_valid", tx_valid, 0);
    hlt = 1;
    tick;
    hlt = 0;
    chk("lat_load_valid", tx_valid, 0);
    chk("lat_load_busy", busy, 1);
    chk("lat_load_addr", rf_rd_addr, 0);
    tick;
    chk("lat_send", {tx_valid, tx_reg, tx_byte_idx}, {1'b1, 5'd0, 3'd0});
    wait_done(0, 0, 1, 400, cyc);
    chk("dump_len_288", cyc, 288);
    chk("done_busy", busy, 0);
    check_stream(0);
    for (int k = 0; k < 12; k++) begin
      if (tv[k].pos < qa.size()) chk($sformatf("vec_pos%0d", tv[k].pos), qa[tv[k].pos], tv[k].e);
      else chk($sformatf("vec_pos%0d_missing", tv[k].pos), qa.size(), tv[k].pos + 1);
    end
    n0 = qa.size();
    hlt = 1;
    repeat (20) begin
      tick;
      chk("post_done", {done, tx_valid, busy}, 3'b100);
    end
    hlt = 0;
    chk("post_done_no_bytes", qa.size(), n0);
    reset = 1;
    tick;
    reset = 0;
    qa.delete();
    hlt = 1;
    tick;
    hlt = 0;
    wait_done(0, 1, 0, 5000, cyc);
    check_stream(0);
    reset = 1;
    tick;
    reset = 0;
    qa.delete();
    hlt = 1;
    tick;
    hlt = 0;
    cyc = 0;
    while (!(tx_valid && tx_reg == 5 && tx_byte_idx == 3) && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("reach_r5_b3", {tx_valid, tx_reg, tx_byte_idx}, {1'b1, 5'd5, 3'd3});
    reset = 1;
    tick;
    chk("midrst", {tx_valid, busy, done}, 3'b000);
    reset = 0;
    qa.delete();
    hlt = 1;
    tick;
    hlt = 0;
    chk("restart_addr", rf_rd_addr, 0);
    tick;
    chk("restart_first", {tx_valid, tx_reg, tx_byte_idx}, {1'b1, 5'd0, 3'd0});
    wait_done(0, 0, 1, 400, cyc);
    check_stream(0);
    hlt2 = 1;
    tick;
    hlt2 = 0;
    wait_done(1, 0, 0, 100, cyc);
    chk("sub_len_18", cyc, 18);
    check_stream(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tinker_reg_dump.md
Name: tinker_reg_dump

Overview:
Post-halt register-file reader for tinker_core. When the core asserts hlt, it walks the register file from FIRST_REG for NUM_REGS entries. It serialises each 64-bit register little-endian onto an 8-bit valid/ready byte stream. This gives benches and the board a result channel in place of hierarchical peeks into reg_file.registers.

Parameters:
NUM_REGS, 32, number of registers dumped; 1..32, with FIRST_REG+NUM_REGS <= 32
FIRST_REG, 0, index of first register dumped
DATA_W, 64, register width; fixed at 64, bytes per register = DATA_W/8 = 8

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
hlt  input  1  halt flag from tinker_core, level
rf_rd_addr  output  5  register-file read address
rf_rd_data  input  64  register-file read data, combinational from rf_rd_addr, valid same cycle
tx_valid  output  1  byte available
tx_ready  input  1  sink accepts byte
tx_byte  output  8  current byte
tx_reg  output  5  register index of current byte
tx_byte_idx  output  3  byte position within register, 0 = LSB
tx_last  output  1  final byte of whole dump
busy  output  1  dump in progress
done  output  1  dump complete, sticky

Behaviour:
- Reset (clk edge with reset=1): state IDLE. tx_valid, tx_byte, tx_reg, tx_byte_idx, tx_last, busy, done = 0. rf_rd_addr = FIRST_REG. Shift register cleared. Reset wins over every other event, including mid-dump; tx_valid is 0 the cycle after the reset edge.
- Handshake: a byte transfers on an edge where tx_valid && tx_ready. Once tx_valid rises, tx_byte/tx_reg/tx_byte_idx/tx_last hold stable until transfer. tx_valid never drops without a transfer, except on reset.
- IDLE: rf_rd_addr = FIRST_REG. If hlt=1 at an edge, go to LOAD and set busy=1.
- LOAD (one cycle, tx_valid=0):
  - rf_rd_addr = current register index.
  - At the edge, latch rf_rd_data into the 64-bit shift register, set tx_byte_idx=0, tx_reg=index, and go to SEND.
- SEND: tx_valid=1, tx_byte = shift[7:0]. tx_last = (index==FIRST_REG+NUM_REGS-1 && tx_byte_idx==7). On transfer:
  - byte_idx<7: shift >>= 8, byte_idx++, stay in SEND. Back-to-back bytes, one per cycle, with no bubble.
  - byte_idx==7, not last register: index++, go to LOAD. This gives one bubble cycle per register.
  - byte_idx==7, last register: go to DONE.
- DONE: busy=0, done=1, tx_valid=0. Stays here until reset; hlt is ignored, so there is one dump per reset.
- Latency: hlt sampled at edge N puts the FSM in LOAD during cycle N+1; tx_valid=1 from edge N+2.
  - Minimum dump length with tx_ready tied high: NUM_REGS*9 cycles from the first LOAD to DONE.
- hlt deasserting mid-dump has no effect; the dump completes.
- Registers are sampled at their own LOAD cycle, not snapshotted at hlt. The core is halted, so contents are static.
- Index arithmetic is 5-bit. NUM_REGS=32 with FIRST_REG=0 ends at index 31 without wrap; the last-register compare uses the full sum, not a wrapped value.
- Total bytes = NUM_REGS*8. tx_last is asserted on exactly one byte.

Test Plan:
- Default params, regs zeroed except r16=247, r17=162, r24=$realtobits(10.0). Pulse hlt one cycle, tx_ready=1.
  - Required: 256 bytes. Reg16 bytes = F7 00 00 00 00 00 00 00. Reg17 byte0 = A2. Reg24 bytes = 00 00 00 00 00 00 24 40.
  - tx_last only on reg31 byte7. done=1 at cycle 288 after first LOAD.
- Latency: hlt rises at edge N. Required: rf_rd_addr=0 during cycle N+1, tx_valid=1 after edge N+2, busy=1 after edge N+1.
- Backpressure: tx_ready random 30% duty, same register image. Required:
  - Identical byte sequence.
  - tx_byte/tx_reg/tx_byte_idx stable whenever tx_valid && !tx_ready.
  - No byte dropped or duplicated.
- Subrange: NUM_REGS=2, FIRST_REG=29, r29=36, r30=12. Required: 16 bytes, first 24 then 00×7, then 0C then 00×7. tx_last on tx_reg=30 idx 7.
- Reset mid-dump: assert reset during reg 5 byte 3. Required:
  - tx_valid=0, busy=0, done=0 after the edge.
  - Re-asserting hlt restarts from reg 0 byte 0.
- Post-done: hold hlt high after done. Required: no new bytes, done stays 1 until reset.
